// File: rtl/mac_array.sv
// NUM_LANES-wide multiply-accumulate array with a shared vector-length control path.
// Operand capture -> product register -> accumulator; Cout is the accumulator itself.
module mac_array #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_LANES  = 4,
  parameter int ACC_WIDTH  = 3*DATA_WIDTH,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            Clr,
  input  logic                            En,
  input  logic                            signed_mode,
  input  logic                            sat_en,
  input  logic [CNT_WIDTH-1:0]            vec_len,
  input  logic [NUM_LANES*DATA_WIDTH-1:0] Ain,
  input  logic [NUM_LANES*DATA_WIDTH-1:0] Bin,
  output logic [NUM_LANES*ACC_WIDTH-1:0]  Cout,
  output logic                            done,
  output logic [NUM_LANES-1:0]            ovf,
  output logic                            busy
);

  localparam int PW = 2*DATA_WIDTH;
  localparam int LW = NUM_LANES*DATA_WIDTH;
  localparam logic [ACC_WIDTH-1:0] SMAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] SMIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  // Control path: element counter and per-vector latched config
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d, len_q, len_d;
  logic                 sgn_q, sgn_d, sat_q, sat_d, fr_q, fr_d;
  logic                 first, is_last, eff_sgn, eff_sat;
  logic [CNT_WIDTH-1:0] eff_len;

  // Stage 0: captured operands with their vector tags and mode
  logic [LW-1:0] a0_q, a0_d, b0_q, b0_d;
  logic          v0_q, v0_d, first0_q, first0_d, last0_q, last0_d;
  logic          sgn0_q, sgn0_d, sat0_q, sat0_d;

  // Stage 1: products
  logic [NUM_LANES*PW-1:0] p1_q, p1_d;
  logic                    v1_q, v1_d, first1_q, first1_d, last1_q, last1_d;
  logic                    sgn1_q, sgn1_d, sat1_q, sat1_d;

  // Stage 2: accumulators
  logic [NUM_LANES*ACC_WIDTH-1:0] acc_q, acc_d;
  logic [NUM_LANES-1:0]           ovf_q, ovf_d;
  logic                           done_q, done_d;

  // Config for the first element comes straight from the ports, later elements use the latch
  always_comb begin
    first    = (cnt_q == '0) && !fr_q;
    eff_len  = first ? vec_len     : len_q;
    eff_sgn  = first ? signed_mode : sgn_q;
    eff_sat  = first ? sat_en      : sat_q;
    is_last  = (eff_len != '0) && ((cnt_q + CNT_WIDTH'(1)) == eff_len);
    cnt_d    = cnt_q;
    len_d    = len_q;
    sgn_d    = sgn_q;
    sat_d    = sat_q;
    fr_d     = fr_q;
    a0_d     = En ? Ain : a0_q;
    b0_d     = En ? Bin : b0_q;
    v0_d     = En;
    first0_d = first;
    last0_d  = is_last;
    sgn0_d   = eff_sgn;
    sat0_d   = eff_sat;
    if (En) begin
      if (first) begin
        len_d = vec_len;
        sgn_d = signed_mode;
        sat_d = sat_en;
        fr_d  = (vec_len == '0);
      end
      cnt_d = (is_last || eff_len == '0) ? '0 : cnt_q + CNT_WIDTH'(1);
    end
  end

  // Operands are extended to PW bits first, so the low PW bits of the product are exact
  always_comb begin
    logic [DATA_WIDTH-1:0] a, b;
    logic [PW-1:0]         ea, eb;
    p1_d     = '0;
    v1_d     = v0_q;
    first1_d = first0_q;
    last1_d  = last0_q;
    sgn1_d   = sgn0_q;
    sat1_d   = sat0_q;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      a  = a0_q[i*DATA_WIDTH +: DATA_WIDTH];
      b  = b0_q[i*DATA_WIDTH +: DATA_WIDTH];
      ea = {{DATA_WIDTH{sgn0_q & a[DATA_WIDTH-1]}}, a};
      eb = {{DATA_WIDTH{sgn0_q & b[DATA_WIDTH-1]}}, b};
      p1_d[i*PW +: PW] = ea * eb;
    end
  end

  always_comb begin
    logic [ACC_WIDTH-1:0] acc_l, ext, res;
    logic [ACC_WIDTH:0]   sum;
    logic                 fill, ov;
    acc_d  = acc_q;
    ovf_d  = ovf_q;
    done_d = v1_q & last1_q;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      acc_l = acc_q[i*ACC_WIDTH +: ACC_WIDTH];
      fill  = sgn1_q & p1_q[i*PW + PW - 1];
      ext   = ACC_WIDTH'({{ACC_WIDTH{fill}}, p1_q[i*PW +: PW]});
      sum   = {1'b0, acc_l} + {1'b0, ext};
      res   = sum[ACC_WIDTH-1:0];
      ov    = sgn1_q ? ((acc_l[ACC_WIDTH-1] == ext[ACC_WIDTH-1]) &&
                        (res[ACC_WIDTH-1] != acc_l[ACC_WIDTH-1]))
                     : sum[ACC_WIDTH];
      if (ov && sat1_q)
        res = sgn1_q ? (acc_l[ACC_WIDTH-1] ? SMIN : SMAX) : '1;
      if (v1_q) begin
        if (first1_q) begin
          acc_d[i*ACC_WIDTH +: ACC_WIDTH] = ext;
          ovf_d[i] = 1'b0;
        end else begin
          acc_d[i*ACC_WIDTH +: ACC_WIDTH] = res;
          ovf_d[i] = ovf_q[i] | ov;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || Clr) begin
      cnt_q <= '0; len_q <= '0; sgn_q <= 1'b0; sat_q <= 1'b0; fr_q <= 1'b0;
      a0_q <= '0; b0_q <= '0; v0_q <= 1'b0; first0_q <= 1'b0; last0_q <= 1'b0;
      sgn0_q <= 1'b0; sat0_q <= 1'b0;
      p1_q <= '0; v1_q <= 1'b0; first1_q <= 1'b0; last1_q <= 1'b0;
      sgn1_q <= 1'b0; sat1_q <= 1'b0;
      acc_q <= '0; ovf_q <= '0; done_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d; len_q <= len_d; sgn_q <= sgn_d; sat_q <= sat_d; fr_q <= fr_d;
      a0_q <= a0_d; b0_q <= b0_d; v0_q <= v0_d; first0_q <= first0_d; last0_q <= last0_d;
      sgn0_q <= sgn0_d; sat0_q <= sat0_d;
      p1_q <= p1_d; v1_q <= v1_d; first1_q <= first1_d; last1_q <= last1_d;
      sgn1_q <= sgn1_d; sat1_q <= sat1_d;
      acc_q <= acc_d; ovf_q <= ovf_d; done_q <= done_d;
    end
  end

  assign Cout = acc_q;
  assign done = done_q;
  assign ovf  = ovf_q;
  assign busy = (cnt_q != '0) | v0_q | v1_q | fr_q;

endmodule

// File: doc/mac_array.md
Name: mac_array

Overview:
- Parametrised, pipelined successor to the single-lane MAC.
- NUM_LANES independent multiply-accumulate lanes share one control path.
- Each lane accumulates a vector of vec_len products, then presents the result with a one-cycle done pulse and restarts with no bubble.
- Adds signed/unsigned mode, optional saturation with a sticky overflow flag, and a 2-stage pipeline (product register, then accumulator). Feeds the matrix-vector datapath.

Parameters:
DATA_WIDTH, 8, width of each lane's Ain/Bin operand
NUM_LANES, 4, number of parallel MAC lanes
ACC_WIDTH, 3*DATA_WIDTH, accumulator width per lane; must be >= 2*DATA_WIDTH
CNT_WIDTH, 16, width of vector-length counter

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
Clr  input  1  synchronous clear; higher priority than En
En  input  1  element valid; Ain/Bin sampled on an edge where En=1
signed_mode  input  1  1 = two's-complement operands and accumulator
sat_en  input  1  1 = saturate on overflow; 0 = wrap
vec_len  input  CNT_WIDTH  elements per vector; 0 = free-running, no done
Ain  input  NUM_LANES*DATA_WIDTH  packed operands, lane i = bits [i*DATA_WIDTH +: DATA_WIDTH]
Bin  input  NUM_LANES*DATA_WIDTH  packed operands, same packing
Cout  output  NUM_LANES*ACC_WIDTH  packed accumulators
done  output  1  one-cycle pulse: Cout holds a completed vector
ovf  output  NUM_LANES  per-lane sticky overflow for current/last vector
busy  output  1  high while a vector is partially accumulated or the pipeline is non-empty

Behaviour:
- Reset (rst=1): Cout=0, done=0, ovf=0, busy=0, element counter=0, pipeline valids=0, latched config=0. rst mid-vector discards all in-flight data.
- Clr=1 (no rst) has the same effect as rst. Clr wins over a simultaneous En; that element is dropped.
- Stage 1, edge where En=1: per-lane product registered at 2*DATA_WIDTH, signed or unsigned per latched mode. p1_valid <= En.
- Stage 2, edge where p1_valid=1: product sign/zero-extended to ACC_WIDTH.
  - First element of a vector: acc <= ext(product). This is a load, not an add; ovf cleared.
  - Otherwise: acc <= acc + ext(product).
- Config latch: signed_mode, sat_en and vec_len are latched when the first element of a vector is sampled. They are held for that vector; mid-vector changes are ignored.
- Element counter:
  - Increments per accepted element.
  - On the element where count+1 == latched vec_len, that element is tagged "last" and the counter returns to 0.
  - The next En element starts a new vector.
- Latency: the last element is sampled at edge k. Final sum appears on Cout, and done=1, in the cycle after edge k+2; done lasts one cycle.
- Cout holds its value until the next vector's first element reaches stage 2.
- Back-to-back: a new vector may begin on edge k+1. Its first product loads the accumulator on edge k+3, so there is no bubble and no mixing between vectors.
- Overflow detection per lane is on the true sum:
  - Unsigned: carry out of ACC_WIDTH.
  - Signed: operand signs equal and result sign differs.
  - On overflow, ovf[i] is set sticky.
  - If sat_en, acc clamps: unsigned max 2^ACC_WIDTH-1; signed max 2^(ACC_WIDTH-1)-1 or min -2^(ACC_WIDTH-1).
  - If not sat_en, acc wraps modulo 2^ACC_WIDTH.
  - Once saturated, acc stays clamped unless a later add moves it back in range (normal arithmetic from the clamped value).
- vec_len=0: accumulate indefinitely, done never asserts, ovf clears only on Clr/rst.
- En gaps mid-vector: stalls only; the counter and accumulator hold.
- busy=1 from the first accepted element until the done cycle. In free-running mode it stays high while any element has been accepted since Clr.

Test Plan:
- Unsigned, vec_len=3, lane0 (2,3),(4,5),(6,7) on edges 0,1,2; other lanes 0 -> Cout lane0=68 and done=1 in the cycle after edge 4; ovf=0.
- Signed, vec_len=2, lane1 (-3,5),(7,-2) -> lane1 = -29 (24'hFFFFE3); lane2 (-128,-128)x2 -> 32768.
- Saturation: signed, sat_en=1, vec_len=512, lane0 (-128,-128) every cycle -> Cout lane0=8388607, ovf[0]=1. Same run with sat_en=0 -> -8388608, ovf[0]=1.
- Unsigned wrap: vec_len=259, lane3 (255,255) -> 64259, ovf[3]=1. With vec_len=258 -> 16776450, ovf[3]=0.
- Back-to-back: vec_len=2, continuous En with lane0 (1,1),(1,1),(2,2),(3,3) -> done pulses two cycles apart, Cout values 2 then 13; second vector ovf is independent.
- Clr at the edge of element 2 of 3, with En=1 -> all outputs 0, the element is dropped; the next 3 elements give an independent result. Same check with rst.
